wb_unified_mem_arbiter: RTL

- Sits directly downstream of custom_riscv_core's two Wishbone masters (iwb instruction-fetch, dwb data).
- Arbitrates both onto one single-port, byte-enabled synchronous SRAM, so code and data share one array (self-modifying code, FENCE.I).
- Owns the tohost mailbox word and raises done/pass flags for synthesizable compliance runs.

---
 rtl/wb_unified_mem_arbiter_pkg.sv | 33 +++
 rtl/sp_sram_bw.sv | 39 +++
 rtl/wb_unified_mem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wb_unified_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// FSM state encoding, grant identifiers, default geometry and a byte-merge
// helper used for the tohost mailbox.
package wb_unified_mem_arbiter_pkg;

   localparam int ADDR_WIDTH_DEFAULT  = 13;    // 8192 words = 32 KB
   localparam int TOHOST_WORD_DEFAULT = 1024;  // byte address 0x1000

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IACK = 2'd1,
      ST_DACK = 2'd2,
      ST_DERR = 2'd3
   } arb_state_e;

   typedef enum logic {
      GRANT_IBUS = 1'b0,
      GRANT_DBUS = 1'b1
   } grant_e;

   // Byte-lane merge: lanes with sel set take new_w, the rest keep old_w.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sp_sram_bw.sv
// Byte-enabled single-port synchronous SRAM, read-first.
// Ports:
//   clk      clock
//   en_i     access enable (read and/or write)
//   we_i     per-byte write enables
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  read data, valid the cycle after en_i
// Instantiated beside the arbiter in the SoC top, not inside it.
module sp_sram_bw #(
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic [3:0]            we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // NOTE: the array and its read register have no reset so that this maps
   // onto a RAM macro; contents survive a core reset.
   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         for (int b = 0; b < 4; b++) begin
            if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_unified_mem_arbiter.sv
// Arbitrates the core's instruction-fetch (iwb) and data (dwb) Wishbone
// masters onto one byte-enabled single-port SRAM, and watches the tohost
// mailbox word to flag end-of-test and pass/fail.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   iwb_*                      fetch port (read-only, address wraps)
//   dwb_*                      data port (read/write, out-of-range -> err)
//   sram_*                     SRAM access; rdata valid 1 cycle after en
//   tohost_o                   last captured mailbox value
//   test_done_o / test_pass_o  sticky done flag, pass = (tohost == 1)
module wb_unified_mem_arbiter
   import wb_unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
   parameter int TOHOST_WORD = TOHOST_WORD_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           iwb_adr_i,
   input  logic                  iwb_cyc_i,
   input  logic                  iwb_stb_i,
   output logic [31:0]           iwb_dat_o,
   output logic                  iwb_ack_o,
   input  logic [31:0]           dwb_adr_i,
   input  logic [31:0]           dwb_dat_i,
   input  logic                  dwb_we_i,
   input  logic [3:0]            dwb_sel_i,
   input  logic                  dwb_cyc_i,
   input  logic                  dwb_stb_i,
   output logic [31:0]           dwb_dat_o,
   output logic                  dwb_ack_o,
   output logic                  dwb_err_o,
   output logic                  sram_en_o,
   output logic [3:0]            sram_we_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [31:0]           sram_wdata_o,
   input  logic [31:0]           sram_rdata_i,
   output logic [31:0]           tohost_o,
   output logic                  test_done_o,
   output logic                  test_pass_o
);

   localparam logic [ADDR_WIDTH-1:0] TOHOST_ADDR = ADDR_WIDTH'(TOHOST_WORD);

   arb_state_e  state_q, state_d;
   grant_e      last_grant_q, last_grant_d;
   logic        iack_q, iack_d;
   logic        dack_q, dack_d;
   logic        derr_q, derr_d;
   logic [31:0] idat_q, ddat_q;
   logic [31:0] tohost_q, tohost_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;

   logic                  ireq, dreq, pick_dbus, dbus_oor;
   logic [ADDR_WIDTH-1:0] iwb_word, dwb_word;
   logic [31:0]           tohost_merged;

   // Fetch addresses wrap, so upper bits and byte offsets are deliberately
   // unused.
   logic unused_bits;
   assign unused_bits = ^{iwb_adr_i[31:ADDR_WIDTH+2], iwb_adr_i[1:0],
                          dwb_adr_i[1:0]};

   assign ireq      = iwb_cyc_i & iwb_stb_i;
   assign dreq      = dwb_cyc_i & dwb_stb_i;
   assign iwb_word  = iwb_adr_i[ADDR_WIDTH+1:2];
   assign dwb_word  = dwb_adr_i[ADDR_WIDTH+1:2];
   assign dbus_oor  = |dwb_adr_i[31:ADDR_WIDTH+2];
   // Round-robin on a tie: the port that did not win last time goes first.
   assign pick_dbus = dreq & (~ireq | (last_grant_q == GRANT_IBUS));
   assign tohost_merged = merge_bytes(tohost_q, dwb_dat_i, dwb_sel_i);

   // Grant-cycle SRAM signals are Mealy outputs of IDLE so the access starts
   // in the same cycle as the request, giving 1-cycle grant-to-ack latency.
   // NOTE: every signal assigned here gets a default first so no latch is
   // inferred on paths that skip an assignment.
   always_comb begin
      state_d      = ST_IDLE;
      last_grant_d = last_grant_q;
      tohost_d     = tohost_q;
      done_d       = done_q;
      pass_d       = pass_q;
      sram_en_o    = 1'b0;
      sram_we_o    = 4'b0000;
      sram_addr_o  = dwb_word;
      sram_wdata_o = dwb_dat_i;

      if (state_q == ST_IDLE) begin
         if (pick_dbus) begin
            last_grant_d = GRANT_DBUS;
            if (dbus_oor) begin
               state_d = ST_DERR;
            end else begin
               state_d   = ST_DACK;
               sram_en_o = 1'b1;
               if (dwb_we_i) begin
                  sram_we_o = dwb_sel_i;
                  if (dwb_word == TOHOST_ADDR && !done_q) begin
                     tohost_d = tohost_merged;
                     if (tohost_merged != 32'd0) begin
                        done_d = 1'b1;
                        pass_d = (tohost_merged == 32'd1);
                     end
                  end
               end
            end
         end else if (ireq) begin
            last_grant_d = GRANT_IBUS;
            state_d      = ST_IACK;
            sram_en_o    = 1'b1;
            sram_addr_o  = iwb_word;
         end
      end
   end

   assign iack_d = (state_d == ST_IACK);
   assign dack_d = (state_d == ST_DACK);
   assign derr_d = (state_d == ST_DERR);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GRANT_IBUS;
         iack_q       <= 1'b0;
         dack_q       <= 1'b0;
         derr_q       <= 1'b0;
         idat_q       <= 32'd0;
         ddat_q       <= 32'd0;
         tohost_q     <= 32'd0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         iack_q       <= iack_d;
         dack_q       <= dack_d;
         derr_q       <= derr_d;
         tohost_q     <= tohost_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         // Each data port keeps the last word it was handed.
         if (iack_q) idat_q <= sram_rdata_i;
         if (dack_q) ddat_q <= sram_rdata_i;
      end
   end

   assign iwb_ack_o   = iack_q;
   assign dwb_ack_o   = dack_q;
   assign dwb_err_o   = derr_q;
   assign iwb_dat_o   = iack_q ? sram_rdata_i : idat_q;
   assign dwb_dat_o   = dack_q ? sram_rdata_i : ddat_q;
   assign tohost_o    = tohost_q;
   assign test_done_o = done_q;
   assign test_pass_o = pass_q;

endmodule
